// File: rtl/rpg_dram_bridge.sv
// rpg_dram_bridge: turns single-record core requests into AXI4-Lite-style DRAM transactions,
// one at a time, with a per-phase watchdog that converts a stuck channel into an error response.
module rpg_dram_bridge #(
    parameter logic [16:0] BASE_ADDR = 17'h10000,
    parameter int          REC_BYTES = 8,
    parameter int          IDX_W     = 8,
    parameter int          DATA_W    = 64,
    parameter int          TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [IDX_W-1:0]  req_idx,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ar_valid,
    output logic [16:0]       ar_addr,
    input  logic              ar_ready,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    output logic              r_ready,
    output logic              aw_valid,
    output logic [16:0]       aw_addr,
    input  logic              aw_ready,
    output logic              w_valid,
    output logic [DATA_W-1:0] w_data,
    input  logic              w_ready,
    input  logic              b_valid,
    input  logic [1:0]        b_resp,
    output logic              b_ready
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW, WR_W, WR_B, RESP} state_t;

    state_t            r_state, w_nxt;
    logic [CW-1:0]     r_cnt;
    logic [16:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_tmo, w_err;
    logic [16:0]       w_addr;

    assign w_tmo  = r_cnt == TMO;
    assign w_addr = (r_state == IDLE) ? BASE_ADDR + 17'(req_idx * REC_BYTES) : r_addr;

    // A handshake is tested before the watchdog so one landing on the last allowed cycle wins.
    always_comb begin
        w_nxt = r_state;
        w_err = 1'b0;
        unique case (r_state)
            IDLE:  if (req_valid) w_nxt = req_write ? WR_AW : RD_AR;
            RD_AR: if (ar_ready) w_nxt = RD_R;
                   else if (w_tmo) begin w_nxt = RESP; w_err = 1'b1; end
            RD_R:  if (r_valid) begin w_nxt = RESP; w_err = r_resp != 2'b00; end
                   else if (w_tmo) begin w_nxt = RESP; w_err = 1'b1; end
            WR_AW: if (aw_ready) w_nxt = WR_W;
                   else if (w_tmo) begin w_nxt = RESP; w_err = 1'b1; end
            WR_W:  if (w_ready) w_nxt = WR_B;
                   else if (w_tmo) begin w_nxt = RESP; w_err = 1'b1; end
            WR_B:  if (b_valid) begin w_nxt = RESP; w_err = b_resp != 2'b00; end
                   else if (w_tmo) begin w_nxt = RESP; w_err = 1'b1; end
            RESP:  w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Every output is a flop loaded from the next state, so it changes together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ar_valid  <= 1'b0;
            ar_addr   <= '0;
            r_ready   <= 1'b0;
            aw_valid  <= 1'b0;
            aw_addr   <= '0;
            w_valid   <= 1'b0;
            w_data    <= '0;
            b_ready   <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_cnt     <= (w_nxt != r_state) ? '0 : r_cnt + 1'b1;
            if (r_state == IDLE && req_valid) begin
                r_addr  <= w_addr;
                r_wdata <= req_wdata;
            end
            req_ready <= w_nxt == IDLE;
            rsp_valid <= w_nxt == RESP;
            rsp_err   <= (w_nxt == RESP) && w_err;
            rsp_rdata <= (r_state == RD_R && r_valid && r_resp == 2'b00) ? r_data : '0;
            ar_valid  <= w_nxt == RD_AR;
            ar_addr   <= (w_nxt == RD_AR) ? w_addr : '0;
            r_ready   <= w_nxt == RD_R;
            aw_valid  <= w_nxt == WR_AW;
            aw_addr   <= (w_nxt == WR_AW) ? w_addr : '0;
            w_valid   <= w_nxt == WR_W;
            w_data    <= (w_nxt == WR_W) ? r_wdata : '0;
            b_ready   <= w_nxt == WR_B;
        end
    end
endmodule

// File: tb/tb_rpg_dram_bridge.sv
// tb_rpg_dram_bridge: directed vectors against hand-computed expectations for the DRAM bridge.
module tb_rpg_dram_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [7:0]  req_idx;
    logic [63:0] req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [16:0] ar_addr, aw_addr;
    logic [63:0] r_data, w_data;
    logic [1:0]  r_resp, b_resp;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;

    int n_chk = 0;
    int n_pass = 0;

    rpg_dram_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_idx(req_idx), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
        .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic wr, input logic [7:0] idx, input logic [63:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_idx   = idx;
        req_wdata = wd;
        check("accept_ready", 64'(req_ready), 64'(1'b1));
        tick();
        req_valid = 1'b0;
    endtask

    logic wr_of [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int n, acc, rsp, acc_cyc;
        rst = 1'b1;
        {req_valid, req_write, req_idx, req_wdata} = '0;
        {ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp} = '0;
        tick(); tick();
        check("rst_req_ready", 64'(req_ready), 64'(1'b1));
        check("rst_valids", 64'({rsp_valid, rsp_err, ar_valid, r_ready, aw_valid, w_valid, b_ready}), 64'(0));
        check("rst_addr", 64'({ar_addr, aw_addr}), 64'(0));
        rst = 1'b0;
        tick();

        // read, DRAM always ready: rsp_valid three cycles after the accept cycle
        ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'b00; r_data = 64'hDEAD_BEEF_0123_4567;
        send(1'b0, 8'h05, 64'h0);
        check("rd_ar_valid", 64'(ar_valid), 64'(1'b1));
        check("rd_ar_addr", 64'(ar_addr), 64'(17'h10028));
        check("rd_req_ready_low", 64'(req_ready), 64'(1'b0));
        tick();
        check("rd_r_ready", 64'({ar_valid, r_ready, rsp_valid}), 64'(3'b010));
        tick();
        check("rd_rsp", 64'({rsp_valid, rsp_err, r_ready}), 64'(3'b100));
        check("rd_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
        tick();
        check("rd_rsp_pulse", 64'({rsp_valid, req_ready}), 64'(2'b01));
        {ar_ready, r_valid} = '0;

        // write with AW held off for five cycles
        send(1'b1, 8'hFF, 64'h1122_3344_5566_7788);
        for (int i = 0; i < 5; i++) begin
            check("wr_aw_hold", 64'({aw_valid, w_valid, aw_addr}), 64'({2'b10, 17'h107F8}));
            tick();
        end
        aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0; w_ready = 1'b1;
        check("wr_w_valid", 64'({aw_valid, w_valid}), 64'(2'b01));
        check("wr_w_data", w_data, 64'h1122_3344_5566_7788);
        tick();
        w_ready = 1'b0; b_valid = 1'b1; b_resp = 2'b00;
        check("wr_b_ready", 64'({w_valid, b_ready}), 64'(2'b01));
        tick();
        b_valid = 1'b0;
        check("wr_rsp", 64'({rsp_valid, rsp_err, b_ready}), 64'(3'b100));
        check("wr_rdata_zero", rsp_rdata, 64'h0);
        tick();

        // read answered with SLVERR
        ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'b10; r_data = 64'hFFFF_0000_FFFF_0000;
        send(1'b0, 8'h03, 64'h0);
        tick(); tick();
        check("slverr_rsp", 64'({rsp_valid, rsp_err}), 64'(2'b11));
        check("slverr_rdata", rsp_rdata, 64'h0);
        {ar_ready, r_valid, r_resp} = '0;
        tick();

        // ar_ready never comes: watchdog fires after the full wait
        send(1'b0, 8'h00, 64'h0);
        n = 0;
        while (ar_valid && n < 2000) begin
            n++;
            tick();
        end
        check("tmo_ar_cycles", 64'(n), 64'(1024));
        check("tmo_rsp", 64'({rsp_valid, rsp_err, ar_valid}), 64'(3'b110));
        check("tmo_rdata", rsp_rdata, 64'h0);
        tick();
        check("tmo_req_ready", 64'(req_ready), 64'(1'b1));
        ar_ready = 1'b1; r_valid = 1'b1; r_data = 64'h0000_0000_CAFE_F00D;
        send(1'b0, 8'h01, 64'h0);
        check("post_tmo_addr", 64'(ar_addr), 64'(17'h10008));
        tick(); tick();
        check("post_tmo_rsp", 64'({rsp_valid, rsp_err}), 64'(2'b10));
        check("post_tmo_rdata", rsp_rdata, 64'h0000_0000_CAFE_F00D);
        {ar_ready, r_valid} = '0;
        tick();

        // handshake on the very last allowed cycle is not an error
        send(1'b0, 8'h02, 64'h0);
        for (int i = 0; i < 1023; i++) tick();
        check("edge_still_ar", 64'(ar_valid), 64'(1'b1));
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'h1234;
        check("edge_to_r", 64'({r_ready, rsp_valid}), 64'(2'b10));
        tick();
        r_valid = 1'b0;
        check("edge_rsp", 64'({rsp_valid, rsp_err}), 64'(2'b10));
        tick();

        // reset while waiting in WR_W abandons the write
        aw_ready = 1'b1;
        send(1'b1, 8'h07, 64'hABCD);
        tick();
        check("rstw_in_w", 64'(w_valid), 64'(1'b1));
        rst = 1'b1; aw_ready = 1'b0;
        tick();
        rst = 1'b0; w_ready = 1'b1; b_valid = 1'b1;
        check("rstw_outputs", 64'({req_ready, rsp_valid, rsp_err, ar_valid, r_ready, aw_valid, w_valid, b_ready}),
              64'(8'b1000_0000));
        check("rstw_data", w_data, 64'h0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) n++;
            tick();
        end
        check("rstw_no_rsp", 64'(n), 64'(0));
        {w_ready, b_valid} = '0;

        // back-to-back with req_valid held high and DRAM always ready
        {ar_ready, r_valid, aw_ready, w_ready, b_valid} = '1;
        {r_resp, b_resp} = '0;
        r_data = 64'hA5A5_0000_0000_5A5A;
        acc = 0; rsp = 0; acc_cyc = 0;
        req_valid = 1'b1; req_write = wr_of[0]; req_idx = 8'h10; req_wdata = 64'h100;
        for (int cyc = 0; cyc < 40 && rsp < 4; cyc++) begin
            if (rsp_valid) begin
                check("b2b_lat", 64'(cyc - acc_cyc), wr_of[rsp] ? 64'(4) : 64'(3));
                check("b2b_rdata", rsp_rdata, wr_of[rsp] ? 64'h0 : 64'hA5A5_0000_0000_5A5A);
                rsp++;
            end
            if (req_ready && acc < 4) begin
                check("b2b_outstanding", 64'(acc), 64'(rsp));
                acc_cyc = cyc;
                acc++;
            end
            tick();
            if (acc < 4) begin
                req_write = wr_of[acc];
                req_idx   = 8'h10 + 8'(acc);
                req_wdata = 64'h100 + 64'(acc);
            end else req_valid = 1'b0;
        end
        check("b2b_count", 64'(rsp), 64'(4));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
